// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared types and byte-lane helpers for the multi-read-port register file
package regfile_mp_pkg;

  typedef enum logic {INIT, READY} state_t;

  // Helpers work on the widest supported word; callers size-cast in and out.
  localparam int MAX_BYTES = 8;
  localparam int MAX_BITS  = 8 * MAX_BYTES;

  function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_BITS-1:0] d);
    logic [MAX_BYTES-1:0] p;
    for (int i = 0; i < MAX_BYTES; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  function automatic logic [MAX_BITS-1:0] be_merge(input logic [MAX_BITS-1:0]  old_w,
                                                   input logic [MAX_BITS-1:0]  new_w,
                                                   input logic [MAX_BYTES-1:0] be);
    logic [MAX_BITS-1:0] m;
    for (int i = 0; i < MAX_BYTES; i++) m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/regfile_init_ctrl.sv
// rtl/regfile_init_ctrl.sv - zero-initialisation sequencer: INIT/READY FSM, clear pointer, init_done and w_err
module regfile_init_ctrl
  import regfile_mp_pkg::*;
#(
  parameter int ADD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 w_en,
  output logic                 clr_we,
  output logic [ADD_WIDTH-1:0] clr_addr,
  output logic                 init_done,
  output logic                 w_err
);

  state_t               state, state_nxt;
  logic [ADD_WIDTH-1:0] clr_ptr, clr_ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
      w_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      w_err   <= w_en & ~init_done;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    case (state)
      INIT: begin
        clr_we = 1'b1;
        if (clr) begin
          clr_ptr_nxt = '0;
        end else if (clr_ptr == '1) begin
          state_nxt   = READY;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_nxt   = INIT;
          clr_ptr_nxt = '0;
        end
      end
    endcase
  end

  assign clr_addr  = clr_ptr;
  assign init_done = (state == READY);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with byte enables, optional registered read and write-first bypass
// Optional per-byte parity is enabled with `define REGFILE_MP_PARITY_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4,
  parameter int NUM_RD     = 2,
  parameter int RD_REG     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  output logic                         init_done,
  input  logic                         w_en,
  input  logic [ADD_WIDTH-1:0]         w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic [DATA_WIDTH/8-1:0]      w_be,
  output logic                         w_err,
  input  logic [NUM_RD*ADD_WIDTH-1:0]  r_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
  input  logic                         par_inj,
  output logic [NUM_RD-1:0]            par_err
);

  localparam int DEPTH = 2 ** ADD_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_we;
  logic [ADD_WIDTH-1:0]  clr_addr;
  logic                  w_acc;
  logic [DATA_WIDTH-1:0] w_word;

  regfile_init_ctrl #(.ADD_WIDTH(ADD_WIDTH)) u_init (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .w_en      (w_en),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done),
    .w_err     (w_err)
  );

  assign w_acc  = w_en & init_done;
  assign w_word = DATA_WIDTH'(be_merge(MAX_BITS'(mem[w_addr]), MAX_BITS'(w_data), MAX_BYTES'(w_be)));

  // Clear and user writes never coincide: users are locked out while INIT runs.
  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_addr] <= '0;
    else if (w_acc) mem[w_addr]   <= w_word;
  end

`ifdef REGFILE_MP_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] w_par;

  assign w_par = ((NB'(byte_parity(MAX_BITS'(w_data))) ^ {NB{par_inj}}) & w_be)
               | (par_mem[w_addr] & ~w_be);

  always_ff @(posedge clk) begin
    if (clr_we)     par_mem[clr_addr] <= '0;
    else if (w_acc) par_mem[w_addr]   <= w_par;
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADD_WIDTH-1:0]  ra;
    logic [DATA_WIDTH-1:0] out_word;
    assign ra = r_addr[k*ADD_WIDTH +: ADD_WIDTH];
`ifdef REGFILE_MP_PARITY_EN
    logic [NB-1:0] out_sp;
`endif

    if (RD_REG != 0) begin : g_reg
      logic                  hit_clr, hit_w;
      logic [DATA_WIDTH-1:0] word_q;
      // Capture what the array will hold after this edge (write-first, clear wins).
      assign hit_clr = clr_we && (clr_addr == ra);
      assign hit_w   = w_acc && (w_addr == ra);
`ifdef REGFILE_MP_PARITY_EN
      logic [NB-1:0] sp_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sp_q <= '0;
        else if (hit_clr) sp_q <= '0;
        else if (hit_w)   sp_q <= w_par;
        else              sp_q <= par_mem[ra];
      end
      assign out_sp = sp_q;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       word_q <= '0;
        else if (hit_clr) word_q <= '0;
        else if (hit_w)   word_q <= w_word;
        else              word_q <= mem[ra];
      end
      assign out_word = word_q;
    end else begin : g_comb
      assign out_word = mem[ra];
`ifdef REGFILE_MP_PARITY_EN
      assign out_sp = par_mem[ra];
`endif
    end

    assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = init_done ? out_word : '0;
`ifdef REGFILE_MP_PARITY_EN
    assign par_err[k] = init_done & (|(NB'(byte_parity(MAX_BITS'(out_word))) ^ out_sp));
`else
    assign par_err[k] = 1'b0;
`endif
  end

endmodule
